// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator with PLL-lock qualification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOCK_WAIT = 16,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LCNT_W  = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [CNT_W-1:0]  c_h_last    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  c_v_last    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  c_h_act     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  c_v_act     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  c_hs_start  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  c_hs_end    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  c_vs_start  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  c_vs_end    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LCNT_W-1:0] c_lock_last = LCNT_W'(LOCK_WAIT - 1);

    typedef enum logic [0:0] {
        S_WAIT_LOCK = 1'b0,
        S_RUN       = 1'b1
    } state_t;

    logic              r_lock_meta;
    logic              r_lock_s;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [LCNT_W-1:0] r_lock_cnt;
    logic [LCNT_W-1:0] w_lock_cnt_nxt;
    logic [CNT_W-1:0]  r_h;
    logic [CNT_W-1:0]  w_h_nxt;
    logic [CNT_W-1:0]  r_v;
    logic [CNT_W-1:0]  w_v_nxt;

    // pll_locked is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_WAIT_LOCK;
            r_lock_cnt <= '0;
            r_h        <= '0;
            r_v        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_h        <= w_h_nxt;
            r_v        <= w_v_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_h_nxt        = r_h;
        w_v_nxt        = r_v;
        case (r_state)
            S_WAIT_LOCK: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (!r_lock_s) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == c_lock_last) begin
                    w_state_nxt    = S_RUN;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss wins over raster advance
                if (!r_lock_s) begin
                    w_state_nxt    = S_WAIT_LOCK;
                    w_lock_cnt_nxt = '0;
                    w_h_nxt        = '0;
                    w_v_nxt        = '0;
                end else if (r_h == c_h_last) begin
                    w_h_nxt = '0;
                    w_v_nxt = (r_v == c_v_last) ? '0 : r_v + 1'b1;
                end else begin
                    w_h_nxt = r_h + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_WAIT_LOCK;
                w_lock_cnt_nxt = '0;
                w_h_nxt        = '0;
                w_v_nxt        = '0;
            end
        endcase
    end

    logic w_run;
    logic w_de;
    logic w_hs_act;
    logic w_vs_act;

    assign w_run    = (r_state == S_RUN);
    assign w_de     = w_run && (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs_act = w_run && (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs_act = w_run && (r_v >= c_vs_start) && (r_v < c_vs_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            de          <= w_de;
            pix_x       <= w_run ? r_h : '0;
            pix_y       <= w_run ? r_v : '0;
            line_start  <= w_run && (r_h == '0);
            frame_start <= w_run && (r_h == '0) && (r_v == '0);
            running     <= w_run;
        end
    end

endmodule

`default_nettype wire
